// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
//
// Holds the loader FSM state encodings, the default frame start byte,
// the default inter-byte timeout and the datapath widths used by
// program_loader and its byte_timeout sub-module.
package program_loader_pkg;

  // Loader FSM states. The encoding is visible on dbg_state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER         = 8'hA5;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 1000000;

  // Instruction address width matches the CPU instruction_pointer.
  localparam int ADDR_W = 8;
  localparam int WORD_W = 32;

  // Count byte to number of words: a count of 0 encodes 256 words.
  function automatic logic [8:0] decode_count(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

  // Frame states in which the loader is actively receiving bytes.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_COUNT) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/program_loader_byte_timeout.sv
// byte_timeout: counts consecutive idle cycles while a frame is running.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-high reset
//   clear   - a byte arrived this cycle; restart the idle count
//   run     - a frame is in progress; the count is held at 0 otherwise
//   expired - high in the TIMEOUT_CYCLES-th consecutive idle cycle, so the
//             consumer acts on the edge that closes that cycle
module byte_timeout
  import program_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  // The counter only needs to reach TIMEOUT_CYCLES-1: the last idle cycle
  // is signalled combinationally instead of being counted.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear || !run) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = run && !clear && (count_q == LAST);

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a framed program over a byte stream and writes
// it into instruction memory while holding the CPU in reset.
//
// Frame: HEADER, N (0 = 256), N x 4 instruction bytes MSB first,
//        checksum = XOR of all payload bytes.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// ready, every strobed byte is consumed in the cycle it is presented, so
// bytes may arrive on consecutive cycles. mem_we is a one-cycle write
// strobe with mem_addr/mem_wdata stable for that cycle; no back-pressure.
//
// Ports:
//   clk, reset          - clock (rising edge), async active-high reset
//   rx_valid, rx_data   - incoming byte stream
//   mem_we, mem_addr,   - instruction memory write port
//   mem_wdata
//   cpu_hold            - CPU held in reset (from frame start until DONE
//                         exits, and throughout ERROR)
//   busy                - frame in progress (COUNT, DATA, CHECK)
//   done                - one-cycle pulse on a successful load
//   error               - level, high in ERROR
//   dbg_state           - current FSM state encoding
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [7:0] HEADER         = DEFAULT_HEADER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  state_t              state_q,      state_d;
  logic                mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic [7:0]          checksum_q,   checksum_d;
  logic [1:0]          byte_cnt_q,   byte_cnt_d;
  logic [8:0]          words_left_q, words_left_d;

  logic                frame_busy;
  logic                timeout_hit;
  logic                header_seen;

  assign frame_busy  = is_busy_state(state_q);
  assign header_seen = rx_valid && (rx_data == HEADER);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid),
    .run    (frame_busy),
    .expired(timeout_hit)
  );

  always_comb begin
    state_d      = state_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    checksum_d   = checksum_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;

    // Address advances on the edge that closes the write pulse, so it is
    // stable for the whole pulse. A new HEADER below overrides this.
    if (mem_we_q) begin
      mem_addr_d = mem_addr_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        // Only a HEADER (re)starts a frame; anything else is dropped.
        if (header_seen) begin
          state_d    = ST_COUNT;
          checksum_d = 8'h00;
          mem_addr_d = '0;
          byte_cnt_d = 2'd0;
        end
      end

      ST_COUNT: begin
        if (rx_valid) begin
          words_left_d = decode_count(rx_data);
          state_d      = ST_DATA;
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
        end
      end

      ST_DATA: begin
        // HEADER-valued bytes land here as ordinary payload.
        if (rx_valid) begin
          mem_wdata_d = {mem_wdata_q[WORD_W-9:0], rx_data};
          checksum_d  = checksum_q ^ rx_data;
          byte_cnt_d  = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            mem_we_d     = 1'b1;
            words_left_d = words_left_q - 1'b1;
            // The checksum byte may arrive during the final write pulse.
            if (words_left_q == 9'd1) begin
              state_d = ST_CHECK;
            end
          end
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
        end
      end

      ST_CHECK: begin
        if (rx_valid) begin
          state_d = (rx_data == checksum_q) ? ST_DONE : ST_ERROR;
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      checksum_q   <= 8'h00;
      byte_cnt_q   <= 2'd0;
      words_left_q <= 9'd0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      checksum_q   <= checksum_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = frame_busy;
  // Every state other than IDLE belongs to a frame or its failed outcome.
  assign cpu_hold  = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign dbg_state = state_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL provide parameter TIMEOUT_CYCLES, default 1000000, the maximum idle cycles allowed between bytes of one frame.
REQ-002 The block SHALL provide parameter HEADER, default 8'hA5, the frame start byte.
REQ-003 The block SHALL provide port clk, input, 1, the single system clock; all logic SHALL be rising-edge clocked.
REQ-004 The block SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL provide port rx_valid, input, 1, a one-cycle strobe marking a received byte.
REQ-006 The block SHALL provide port rx_data, input, 8, the byte qualified by rx_valid.
REQ-007 The block SHALL provide port mem_we, output, 1, the instruction-memory write strobe.
REQ-008 The block SHALL provide port mem_addr, output, 8, the instruction address, matching the CPU instruction_pointer width.
REQ-009 The block SHALL provide port mem_wdata, output, 32, the assembled instruction word.
REQ-010 The block SHALL provide port cpu_hold, output, 1, high while the CPU must be held in reset (CPU resetn = ~cpu_hold & system resetn).
REQ-011 The block SHALL provide port busy, output, 1, high while a frame is in progress.
REQ-012 The block SHALL provide port done, output, 1, a one-cycle pulse on successful load.
REQ-013 The block SHALL provide port error, output, 1, a level that is high in ERROR state.

Function
REQ-014 Frame format SHALL be: HEADER, count N (0 encodes 256), then N instructions of 4 bytes each, MSB first, then one checksum byte equal to the XOR of all 4N payload bytes.
REQ-015 States SHALL be IDLE, COUNT, DATA, CHECK, DONE and ERROR.
REQ-016 In IDLE and ERROR, rx_valid with rx_data==HEADER SHALL enter COUNT, clear the checksum, and set mem_addr to 0; other bytes SHALL be ignored.
REQ-017 In COUNT, rx_valid SHALL latch N into the remaining-word counter and enter DATA.
REQ-018 In DATA, each byte SHALL shift into mem_wdata from the LSB end and XOR into the checksum, tracked by a 2-bit byte counter.
REQ-019 On the 4th byte of a word, mem_we SHALL pulse high for exactly the next cycle, with mem_addr/mem_wdata stable during that pulse.
REQ-020 mem_addr SHALL increment by 1 on the cycle after each mem_we pulse, wrapping 255->0.
REQ-021 After the Nth word's write, the state SHALL go to CHECK.
REQ-022 In CHECK, a byte equal to the checksum SHALL enter DONE; a mismatch SHALL enter ERROR.
REQ-023 DONE SHALL last one cycle, assert done during it, and then return to IDLE.
REQ-024 cpu_hold SHALL be high from the cycle after the HEADER is accepted until DONE is exited, and SHALL stay high in ERROR.
REQ-025 busy SHALL be high in COUNT, DATA and CHECK.
REQ-026 In COUNT, DATA or CHECK, TIMEOUT_CYCLES consecutive cycles without rx_valid SHALL enter ERROR.
REQ-027 A HEADER byte received mid-frame SHALL be treated as data, not as a restart.
REQ-028 rx_valid asserted on consecutive cycles SHALL be accepted at one byte per cycle, with no byte dropped.
REQ-029 Words already written before an ERROR SHALL NOT be rolled back.

Reset
REQ-030 Reset SHALL force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, checksum=0, and all counters to 0, effective immediately and regardless of state.

Structure
REQ-031 State encodings and the HEADER default SHALL live in cpu_definitions.vh, alongside the existing CPU constants.
REQ-032 The timeout counter SHALL be a sub-module named byte_timeout (inputs: clk, reset, clear, run; output: expired).

Verification
REQ-033 Frame A5,01,12,34,56,78,08 (checksum 0x12^0x34^0x56^0x78=0x08) -> a single mem_we pulse with addr 0x00 and data 0x12345678, then done pulses and cpu_hold falls.
REQ-034 N=3 with back-to-back bytes -> writes to addresses 0, 1 and 2 in order, with no byte lost, then done.
REQ-035 Correct frame with the checksum byte corrupted -> error=1, cpu_hold=1, no done; a following valid frame -> done, error=0.
REQ-036 TIMEOUT_CYCLES=16 and the stream stopping after 2 data bytes -> error on cycle 16 after the last byte, with no mem_we.
REQ-037 N=0 (256 words) -> 256 writes, mem_addr wraps to 0x00, then done.
REQ-038 reset asserted mid-DATA -> IDLE immediately with all outputs 0; bytes that follow without a HEADER -> ignored.
